fifo_rd_packer: RTL



---
 rtl/fifo_pack_pkg.sv | 36 +++
 rtl/fifo_pack_idle_timer.sv | 32 +++
 rtl/fifo_rd_packer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fifo_pack_pkg.sv
// Shared constants and helpers for the FIFO read-side packer.
package fifo_pack_pkg;

  // Default geometry: 8-bit FIFO entries packed four to a word.
  localparam int DEF_DSIZE   = 8;
  localparam int DEF_NLANES  = 4;
  localparam int DEF_TIMEOUT = 16;

  // Widest keep mask the helper below can produce.
  localparam int MAX_LANES = 64;

  // Lane counter must represent 0..NLANES inclusive.
  localparam int LANE_CNT_W = $clog2(DEF_NLANES + 1);

  // Idle counter must represent 0..TIMEOUT inclusive.
  localparam int IDLE_CNT_W = $clog2(DEF_TIMEOUT + 1);

  function automatic int laneCountWidth(input int nlanes);
    return $clog2(nlanes + 1);
  endfunction

  function automatic int idleWidth(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  // Thermometer mask: the low 'count' bits set, everything above cleared.
  function automatic logic [MAX_LANES-1:0] keepMask(input int count);
    logic [MAX_LANES-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (i < count) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/fifo_pack_idle_timer.sv
// Saturating idle counter: counts enabled cycles since the last clear and
// flags when TIMEOUT has been reached.
module fifo_pack_idle_timer
  import fifo_pack_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int IW = idleWidth(TIMEOUT);

  logic [IW-1:0] r_idle;

  // Clear wins over counting; the counter parks at TIMEOUT once it gets there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle <= '0;
    end else if (i_clear) begin
      r_idle <= '0;
    end else if (i_enable && (r_idle != IW'(TIMEOUT))) begin
      r_idle <= r_idle + IW'(1);
    end
  end

  assign o_expired = (r_idle == IW'(TIMEOUT));

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-domain FIFO consumer: pops entries, packs NLANES of them into one wide
// word and hands words out on a valid/ready stream. Partial words leave on
// flush or after an idle timeout, with a keep mask marking the live lanes.
module fifo_rd_packer
  import fifo_pack_pkg::*;
#(
  parameter int DSIZE   = DEF_DSIZE,
  parameter int NLANES  = DEF_NLANES,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                    rclk,
  input  logic                    rrst_n,
  input  logic                    rempty,
  input  logic [DSIZE-1:0]        rdata,
  output logic                    rinc,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DSIZE*NLANES-1:0] out_data,
  output logic [NLANES-1:0]       out_keep
);

  localparam int CW = laneCountWidth(NLANES);

  logic [NLANES-1:0][DSIZE-1:0] r_acc;
  logic [CW-1:0]                r_cnt;
  logic [DSIZE*NLANES-1:0]      r_outData;
  logic [NLANES-1:0]            r_outKeep;
  logic                         r_outValid;

  logic                    w_outFree;
  logic                    w_full;
  logic                    w_hasData;
  logic                    w_timeout;
  logic                    w_xfer;
  logic                    w_pop;
  logic                    w_idleClear;
  logic [NLANES-1:0]       w_keep;
  logic [NLANES-1:0]       w_laneWe;
  logic [DSIZE*NLANES-1:0] w_wordData;

  // The output register can take a new word when it is empty or draining now.
  assign w_outFree = !r_outValid || out_ready;
  assign w_full    = (r_cnt == CW'(NLANES));
  assign w_hasData = (r_cnt != '0);

  // A word moves to the output on a full accumulator, or early on flush/timeout.
  assign w_xfer = w_outFree && (w_full || (w_hasData && (flush || w_timeout)));

  // Keep popping while there is room, including the cycle the accumulator empties.
  assign w_pop = rrst_n && !rempty && (!w_full || w_xfer);

  assign w_keep      = NLANES'(keepMask(int'(r_cnt)));
  assign w_idleClear = w_pop || w_xfer || !w_hasData;

  // Pick the lane the popped entry lands in and build the masked outgoing word.
  always_comb begin
    w_laneWe   = '0;
    w_wordData = '0;
    for (int i = 0; i < NLANES; i++) begin
      if (w_pop) begin
        w_laneWe[i] = w_xfer ? (i == 0) : (r_cnt == CW'(i));
      end
      w_wordData[i*DSIZE +: DSIZE] = w_keep[i] ? r_acc[i] : '0;
    end
  end

  // Accumulator lanes capture the FIFO head when selected.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_acc <= '0;
    end else begin
      for (int i = 0; i < NLANES; i++) begin
        if (w_laneWe[i]) r_acc[i] <= rdata;
      end
    end
  end

  // Lane count: a pop during a transfer starts the next word at one entry.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_cnt <= '0;
    end else if (w_xfer) begin
      r_cnt <= w_pop ? CW'(1) : '0;
    end else if (w_pop) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Output register: load on transfer, drop valid once accepted, hold payload.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_outData  <= '0;
      r_outKeep  <= '0;
      r_outValid <= 1'b0;
    end else if (w_xfer) begin
      r_outData  <= w_wordData;
      r_outKeep  <= w_keep;
      r_outValid <= 1'b1;
    end else if (out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  fifo_pack_idle_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_idleTimer (
    .clk      (rclk),
    .rst_n    (rrst_n),
    .i_clear  (w_idleClear),
    .i_enable (w_hasData),
    .o_expired(w_timeout)
  );

  assign rinc      = w_pop;
  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign out_keep  = r_outKeep;

endmodule
